constant_weight_gen: RTL
========================

Name: constant_weight_gen

Overview:
- Inverse of the population-count path: takes a ones-count k and streams every 2**log_bit_width-bit word that has exactly k ones, in strictly increasing numeric order.
- Sources test vectors and exhaustive constant-weight patterns for the popcount datapath and its bench.
- Output uses a valid/ready stream; one word per cycle when the sink is ready.

Parameters:
- log_bit_width, 5, log2 of word width; N = 2**log_bit_width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to begin a sequence; sampled only when busy=0
- count_in  in  log_bit_width+1  requested weight k (0..N valid)
- word_out  out  N  current constant-weight word
- out_valid  out  1  word_out valid
- out_ready  in  1  sink accepts word_out when out_valid=1
- last  out  1  word_out is the final word of the sequence; qualified by out_valid
- idx_out  out  N  zero-based index of word_out within the sequence
- busy  out  1  sequence in progress
- err  out  1  one-cycle pulse: start with count_in > N

Behaviour:
- Reset (async, rst_n=0): state IDLE; word_out=0, out_valid=0, last=0, idx_out=0, busy=0, err=0. Reset mid-sequence abandons it immediately; no further words after release until a new start.
- States: IDLE, EMIT.
- IDLE, start=1, count_in<=N: next cycle EMIT, busy=1, out_valid=1, word_out=(1<<k)-1, idx_out=0. Latency start->first valid = 1 cycle.
- IDLE, start=1, count_in>N: err=1 for exactly one cycle, remain IDLE, out_valid stays 0.
- start while busy=1: ignored, no err.
- EMIT: a handshake is out_valid & out_ready. Without a handshake, word_out, last and idx_out hold stable.
- On a handshake with last=0, word_out advances to the next word in the same cycle, and idx_out increments by 1.
- On a handshake with last=1, the next state is IDLE; out_valid=0 and busy=0 next cycle. word_out and idx_out hold their last values. A start in the first IDLE cycle is accepted normally.
- Next-word rule, computed in a single cycle (x = current word, all arithmetic N-bit plus carry):
  - c = x & (~x+1)
  - r = x + c
  - next = r | ((r ^ x) >> (tz(x)+2)), where tz = trailing-zero count of x.
- last is the carry-out of x + c (equivalent to x == ((1<<k)-1) << (N-k)).
- For k=0, x=0 gives c=0 and no carry, so last is forced when k=0. k=N yields last by carry.
- Sequence length is C(N,k), and C(N,k) < 2**N, so idx_out never wraps.
- k latched at start; count_in changes during EMIT have no effect.
- No combinational path from out_ready to out_valid.

Decomposition:
- Shared package: N derived constant, state encoding (IDLE/EMIT), and a trailing-zero-count function.
- Natural sub-module: cwg_next, purely combinational. Inputs are x and k; outputs are the next word and the last flag.
- The bench reuses the existing ones-counter block as an on-the-fly weight checker on word_out.

Test Plan:
- log_bit_width=3, k=2, out_ready=1:
  - 28 words: 0x03, 0x05, 0x06, 0x09, 0x0A, 0x0C, 0x11, ... ending 0xC0 with last=1 at idx_out=27.
  - Each word has weight 2 and the sequence is strictly increasing.
- k=0 -> single word 0x00, last=1, idx_out=0. Then busy=0 one cycle after the handshake.
- k=8 (N=8) -> single word 0xFF, last=1. k=9 -> err pulse of 1 cycle, out_valid never asserts.
- Backpressure: k=3, out_ready toggled pseudo-randomly -> word_out/idx_out stable while stalled. All 56 words delivered exactly once, in order. A start issued mid-sequence is ignored.
- Reset mid-operation: k=4, assert rst_n=0 after 10 handshakes -> outputs zero asynchronously. After release, a start with k=1 yields 0x01 at idx_out=0.
- log_bit_width=5, k=31 -> 32 words, first 0x7FFFFFFF, last 0xFFFFFFFE, no idx wrap.

Source files
------------

// File: rtl/constant_weight_gen_pkg.sv
// Shared definitions for the constant-weight word generator: word width helper,
// state encoding and the trailing-zero counter used by the next-word logic.
package constant_weight_gen_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  function automatic int unsigned wordWidth(input int unsigned logBitWidth);
    return 32'd1 << logBitWidth;
  endfunction

  // Returns width when x has no set bit within the low width bits.
  function automatic logic [7:0] trailingZeros(input logic [MAX_WIDTH-1:0] x, input int width);
    logic [7:0] tz;
    tz = 8'(width);
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      if (i < width && x[i]) tz = 8'(i);
    end
    return tz;
  endfunction

endpackage

// File: rtl/constant_weight_gen_if.sv
// Output stream of the constant-weight generator: word, index, last flag and
// a valid/ready handshake.
interface constant_weight_gen_if
  import constant_weight_gen_pkg::*;
#(
  parameter int unsigned log_bit_width = 5
);
  localparam int unsigned N = wordWidth(log_bit_width);

  logic [N-1:0] word_out;
  logic         out_valid;
  logic         out_ready;
  logic         last;
  logic [N-1:0] idx_out;

  modport master (
    output word_out,
    output out_valid,
    input  out_ready,
    output last,
    output idx_out
  );

  modport slave (
    input  word_out,
    input  out_valid,
    output out_ready,
    input  last,
    input  idx_out
  );
endinterface

// File: rtl/constant_weight_gen_cwg_next.sv
// Combinational successor of a constant-weight word: the next larger word with
// the same number of ones, plus a flag marking the final word of the sequence.
module cwg_next
  import constant_weight_gen_pkg::*;
#(
  parameter  int unsigned log_bit_width = 5,
  localparam int unsigned N = wordWidth(log_bit_width)
) (
  input  logic [N-1:0]         x_i,
  input  logic [log_bit_width:0] k_i,
  output logic [N-1:0]         next_o,
  output logic                 last_o
);

  logic [N-1:0] lowBit;
  logic [N-1:0] sum;
  logic [N-1:0] diff;
  logic         carry;
  logic [7:0]   tz;

  // Ripple the lowest run of ones up by one and refill its remainder at the bottom.
  always_comb begin
    lowBit       = x_i & (~x_i + N'(1));
    {carry, sum} = {1'b0, x_i} + {1'b0, lowBit};
    tz           = trailingZeros(MAX_WIDTH'(x_i), int'(N));
    diff         = sum ^ x_i;
    next_o       = sum | (diff >> (tz + 8'd2));
    last_o       = carry | (k_i == '0);
  end

endmodule

// File: rtl/constant_weight_gen.sv
// Streams every N-bit word with exactly k ones in increasing order, one word
// per accepted handshake.
module constant_weight_gen
  import constant_weight_gen_pkg::*;
#(
  parameter  int unsigned log_bit_width = 5,
  localparam int unsigned N = wordWidth(log_bit_width)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [log_bit_width:0] count_in,
  output logic                   busy,
  output logic                   err,
  constant_weight_gen_if.master  stream
);

  logic [0:0]             state_q, state_d;
  logic [N-1:0]           word_q, word_d;
  logic [N-1:0]           idx_q, idx_d;
  logic [log_bit_width:0] k_q, k_d;
  logic                   err_q, err_d;
  logic [N-1:0]           nextWord;
  logic                   nextLast;
  logic                   handshake;
  logic                   badCount;

  cwg_next #(.log_bit_width(log_bit_width)) u_next (
    .x_i    (word_q),
    .k_i    (k_q),
    .next_o (nextWord),
    .last_o (nextLast)
  );

  assign badCount  = count_in[log_bit_width] & (|count_in[log_bit_width-1:0]);
  assign handshake = (state_q == EMIT) & stream.out_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    k_d     = k_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (badCount) begin
            err_d = 1'b1;
          end else begin
            // The smallest word of weight k is its k low bits set.
            state_d = EMIT;
            k_d     = count_in;
            word_d  = ~({N{1'b1}} << count_in);
            idx_d   = '0;
          end
        end
      end
      EMIT: begin
        if (handshake) begin
          if (nextLast) begin
            state_d = IDLE;
          end else begin
            word_d = nextWord;
            idx_d  = idx_q + N'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  assign stream.word_out  = word_q;
  assign stream.idx_out   = idx_q;
  assign stream.out_valid = (state_q == EMIT);
  assign stream.last      = (state_q == EMIT) & nextLast;
  assign busy             = (state_q == EMIT);
  assign err              = err_q;

endmodule
